mel_frame_ctrl: RTL
===================

// Module: mel_frame_ctrl
// PURPOSE
//  Frame sequencer between the FFT output stream and mel_filter. Detects frame start (bin 0),
//  checks bin-index continuity, gates bins into mel_filter, waits for its per-frame result,
//  and holds that result in a one-deep buffer with valid/ready toward the log stage.
//  Counts frames, dropped frames and result overflows; flushes mel_filter on broken frames.
// PARAMETERS
//  DW       14    width of FFT real/imag samples
//  NW       10    width of bin index
//  N_BINS   1024  bins per frame (last accepted index = N_BINS-1)
//  MEL_W    470   width of packed mel_filter result
//  FRAME_W  16    width of frame counter
//  TIMEOUT  4096  WAIT_MEL watchdog limit in cycles (only with MEL_CTRL_TIMEOUT_EN)
// PORTS
//  clk           in   1      clock, rising edge
//  rst_n         in   1      reset, asynchronous, active-low
//  fft_valid     in   1      FFT bin valid (no backpressure on this side)
//  fft_num       in   NW     FFT bin index
//  fft_re/fft_im in   DW     FFT bin value
//  mel_in_valid  out  1      to mel_filter in_valid
//  mel_in_num    out  NW     to mel_filter in_num
//  mel_in_re/im  out  DW     to mel_filter in_re / in_im
//  mel_flush     out  1      1-cycle pulse: clear mel_filter accumulators
//  mel_out       in   MEL_W  mel_filter result
//  mel_out_valid in   1      mel_filter result valid (1-cycle pulse)
//  out_data      out  MEL_W  held mel result
//  out_frame     out  FRAME_W frame number of out_data
//  out_valid     out  1      held result valid
//  out_ready     in   1      downstream accepts when out_valid & out_ready
//  busy          out  1      state != IDLE
//  err_seq       out  1      sticky: bin-index discontinuity seen
//  err_timeout   out  1      sticky: WAIT_MEL watchdog expired
//  err_clr       in   1      clears err_seq/err_timeout (set wins on same cycle)
//  drop_cnt      out  8      frames dropped (saturating)
//  ovf_cnt       out  8      results lost to full hold buffer (saturating)
// BEHAVIOUR
//  Reset: state IDLE, expected=0, all outputs 0 (incl. counters, frame counter, out_data).
//  States: IDLE -> STREAM -> WAIT_MEL -> IDLE.
//  IDLE: fft_valid & fft_num==0 -> forward, expected=1, STREAM. Other bins ignored, no count.
//  STREAM: fft_valid & fft_num==expected -> forward, expected++; if fft_num==N_BINS-1 -> WAIT_MEL.
//   fft_valid & fft_num!=expected -> bin not forwarded, err_seq=1, drop_cnt++, mel_flush
//   pulse next cycle, IDLE (offending bin discarded even if it is 0). Gaps (fft_valid=0) allowed.
//  Forwarding: mel_in_* registered, exactly 1 cycle after the accepted fft_* beat; mel_in_valid
//   low otherwise; mel_in_num/re/im hold last value when not valid.
//  WAIT_MEL: all fft beats ignored; fft_num==0 beat -> drop_cnt++. On mel_out_valid -> IDLE,
//   frame counter++ (wraps 2^FRAME_W-1 -> 0), result offered to hold buffer tagged with new count-1.
//  Hold buffer: loads if empty, or if full and being popped (out_valid&out_ready) same cycle;
//   else result discarded, ovf_cnt++. out_valid rises the cycle after load, falls the cycle
//   after pop; out_data/out_frame stable while out_valid=1.
//  mel_out_valid outside WAIT_MEL: ignored, no counter change.
//  Counters saturate at 255. Hold buffer independent of input FSM (next frame streams while held).
// CONFIGURATION
//  MEL_CTRL_TIMEOUT_EN defined: cycle counter in WAIT_MEL; at TIMEOUT cycles w/o mel_out_valid
//   -> err_timeout=1, drop_cnt++, mel_flush pulse, IDLE; mel_out_valid on that same cycle wins.
//  Not defined: WAIT_MEL waits indefinitely; err_timeout tied 0; no watchdog logic.
// TESTING
//  Clean frame: bins 0..1023 back-to-back, mel_out_valid 5 cyc later, out_ready=1 -> 1024
//   mel_in_valid beats, out_valid 1 cycle, out_frame=0, all errors/counters 0.
//  Backpressure: out_ready=0, two clean frames -> first held (out_frame=0), ovf_cnt=1; ready=1
//   -> pop, out_valid drops next cycle.
//  Sequence error: bins 0..99 then 101 -> err_seq=1, drop_cnt=1, one mel_flush, IDLE; next
//   clean frame completes normally with out_frame=0.
//  Timeout (macro on, TIMEOUT=16): frame with no mel_out_valid -> err_timeout at cycle 16 of
//   WAIT_MEL, mel_flush, drop_cnt=1; macro off -> busy stays 1.
//  Reset mid-STREAM at bin 500: all outputs 0 immediately; next bin 0 starts fresh frame.
//  Wrap: FRAME_W=2, five frames -> out_frame 0,1,2,3,0.

Source files
------------

// File: rtl/mel_frame_ctrl.sv
// Frame sequencer between the FFT bin stream and mel_filter: frame detection, bin continuity, result hold buffer.
// Optional WAIT_MEL watchdog enabled by defining MEL_CTRL_TIMEOUT_EN.
module mel_frame_ctrl #(
    parameter int DW      = 14,
    parameter int NW      = 10,
    parameter int N_BINS  = 1024,
    parameter int MEL_W   = 470,
    parameter int FRAME_W = 16,
    parameter int TIMEOUT = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               fft_valid,
    input  logic [NW-1:0]      fft_num,
    input  logic [DW-1:0]      fft_re,
    input  logic [DW-1:0]      fft_im,
    output logic               mel_in_valid,
    output logic [NW-1:0]      mel_in_num,
    output logic [DW-1:0]      mel_in_re,
    output logic [DW-1:0]      mel_in_im,
    output logic               mel_flush,
    input  logic [MEL_W-1:0]   mel_out,
    input  logic               mel_out_valid,
    output logic [MEL_W-1:0]   out_data,
    output logic [FRAME_W-1:0] out_frame,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               busy,
    output logic               err_seq,
    output logic               err_timeout,
    input  logic               err_clr,
    output logic [7:0]         drop_cnt,
    output logic [7:0]         ovf_cnt
);

    typedef enum logic [1:0] {IDLE, STREAM, WAIT_MEL} state_t;

    localparam logic [NW-1:0] LAST_BIN = NW'(N_BINS - 1);

    state_t             state;
    state_t             state_nxt;
    logic [NW-1:0]      expected;
    logic               accept;
    logic               seq_err;
    logic               wait_zero;
    logic               res_take;
    logic               tmo;
    logic               pop;
    logic               load;
    logic [FRAME_W-1:0] frame_cnt;
    logic [1:0]         drop_inc;
    logic [8:0]         drop_sum;

`ifdef MEL_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT) + 1;
    logic [TW-1:0] wait_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt <= '0;
        end else if (state == WAIT_MEL) begin
            wait_cnt <= wait_cnt + 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    // A result arriving on the expiry cycle takes priority over the watchdog.
    assign tmo = (state == WAIT_MEL) && !mel_out_valid && (wait_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_timeout <= 1'b0;
        end else if (tmo) begin
            err_timeout <= 1'b1;
        end else if (err_clr) begin
            err_timeout <= 1'b0;
        end
    end
`else
    assign tmo         = 1'b0;
    assign err_timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (fft_valid && (fft_num == '0)) begin
                    state_nxt = STREAM;
                end
            end
            STREAM: begin
                if (fft_valid) begin
                    if (fft_num != expected) begin
                        state_nxt = IDLE;
                    end else if (fft_num == LAST_BIN) begin
                        state_nxt = WAIT_MEL;
                    end
                end
            end
            WAIT_MEL: begin
                if (mel_out_valid || tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        accept    = 1'b0;
        seq_err   = 1'b0;
        wait_zero = 1'b0;
        res_take  = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                accept = fft_valid && (fft_num == '0);
            end
            STREAM: begin
                accept  = fft_valid && (fft_num == expected);
                seq_err = fft_valid && (fft_num != expected);
            end
            WAIT_MEL: begin
                wait_zero = fft_valid && (fft_num == '0);
                res_take  = mel_out_valid;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            expected <= '0;
        end else if (accept) begin
            expected <= fft_num + 1'b1;
        end else if (state_nxt == IDLE) begin
            expected <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mel_in_valid <= 1'b0;
            mel_in_num   <= '0;
            mel_in_re    <= '0;
            mel_in_im    <= '0;
            mel_flush    <= 1'b0;
        end else begin
            mel_in_valid <= accept;
            mel_flush    <= seq_err | tmo;
            if (accept) begin
                mel_in_num <= fft_num;
                mel_in_re  <= fft_re;
                mel_in_im  <= fft_im;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_seq <= 1'b0;
        end else if (seq_err) begin
            err_seq <= 1'b1;
        end else if (err_clr) begin
            err_seq <= 1'b0;
        end
    end

    // A bin-0 beat in WAIT_MEL and a watchdog expiry can coincide, so the increment is 0..2.
    assign drop_inc = {1'b0, seq_err} + {1'b0, wait_zero} + {1'b0, tmo};
    assign drop_sum = {1'b0, drop_cnt} + {7'd0, drop_inc};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt <= '0;
        end else if (drop_sum[8]) begin
            drop_cnt <= 8'hFF;
        end else begin
            drop_cnt <= drop_sum[7:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
        end else if (res_take) begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    assign pop  = out_valid & out_ready;
    assign load = res_take & (~out_valid | pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_frame <= '0;
        end else if (load) begin
            out_valid <= 1'b1;
            out_data  <= mel_out;
            out_frame <= frame_cnt;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_cnt <= '0;
        end else if (res_take && !load && (ovf_cnt != 8'hFF)) begin
            ovf_cnt <= ovf_cnt + 1'b1;
        end
    end

endmodule
